inst_encoder: RTL

- Inverse of the instruction field decoder. Accepts RV32I instruction fields (5-bit opcode = inst[6:2], func3, func7, rs1, rs2, rd, immediate) over a valid/ready handshake.
- Packs the immediate according to the format implied by the opcode and appends inst[1:0] = 2'b11.
- Buffers the finished 32-bit words with sequential addresses in a small FIFO.
- Used by the self-test program loader and the testbench stimulus path to fill instruction memory.

---
 rtl/inst_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words and queues
// them, each tagged with a sequential word address, in a small output FIFO.
module inst_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_illegal,
  output logic [7:0]  illegal_count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Returns {illegal, word}; illegal opcodes become addi x0,x0,0.
  function automatic logic [32:0] encode(
    input logic [4:0]  opc,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        ill;
    w   = 32'h0;
    ill = 1'b0;
    case (opc)
      5'b01100: w[31:7] = {f7, rs2, rs1, f3, rd};
      5'b00000, 5'b11001, 5'b11100:
        w[31:7] = {imm[11:0], rs1, f3, rd};
      5'b00100: begin
        // Shift-immediates carry func7 above a 5-bit shamt.
        if (f3 == 3'b001 || f3 == 3'b101)
          w[31:7] = {f7, imm[4:0], rs1, f3, rd};
        else
          w[31:7] = {imm[11:0], rs1, f3, rd};
      end
      5'b01000: w[31:7] = {imm[11:5], rs2, rs1, f3, imm[4:0]};
      5'b11000: w[31:7] = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]};
      5'b01101, 5'b00101: w[31:7] = {imm[31:12], rd};
      5'b11011: w[31:7] = {imm[20], imm[10:1], imm[11], imm[19:12], rd};
      default: ill = 1'b1;
    endcase
    if (ill)
      w = 32'h0000_0013;
    else
      w[6:0] = {opc, 2'b11};
    return {ill, w};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  logic [32:0]   enc_p0;
  logic [31:0]   addr_p0;
  logic          push, pop, full, empty;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   inst_p1 [DEPTH];
  logic [31:0]   addr_p1 [DEPTH];
  logic          ill_p1  [DEPTH];

  // p0: combinational encode and the running address
  assign enc_p0   = encode(in_opcode, in_func3, in_func7, in_rs1, in_rs2, in_rd, in_imm);
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      addr_p0       <= BASE_ADDR;
      illegal_count <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        addr_p0 <= addr_p0 + 32'd4;
        if (enc_p0[32])
          illegal_count <= sat_inc(illegal_count);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (!push && pop)
        count <= count - (AW+1)'(1);
    end
  end

  // p1: FIFO storage; contents are only visible through a valid head
  always_ff @(posedge clk) begin
    if (push) begin
      inst_p1[wr_ptr] <= enc_p0[31:0];
      addr_p1[wr_ptr] <= addr_p0;
      ill_p1[wr_ptr]  <= enc_p0[32];
    end
  end

  assign out_inst    = empty ? 32'h0 : inst_p1[rd_ptr];
  assign out_addr    = empty ? 32'h0 : addr_p1[rd_ptr];
  assign out_illegal = empty ? 1'b0  : ill_p1[rd_ptr];

endmodule
